hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations after ID, selects forwarding sources
// and raises a load-use stall. Optional stall statistics counter enabled by SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int NSRC     = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_RDY = 1,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [NSRC*REG_AW-1:0] id_src_addr,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]      id_dst_addr,
  input  logic                   id_dst_we,
  input  logic                   id_is_load,
  input  logic                   flush,
  input  logic                   kill_ex,
`ifdef SCOREBOARD_STATS_EN
  output logic [15:0]            stall_cnt,
`endif
  output logic                   stall,
  output logic [NSRC*SELW-1:0]   fwd_sel
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             we_q, we_d;
  logic [DEPTH-1:0]             load_q, load_d;
  logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [DEPTH-1:0]             vld_eff;
  logic                         hazard;
  logic                         issue;
  logic [REG_AW-1:0]            src;
  logic [SELW-1:0]              sel;
  logic                         ld_hit;

  // Scan oldest to youngest so the youngest matching stage overwrites the selection.
  always_comb begin
    vld_eff    = valid_q;
    vld_eff[0] = valid_q[0] & ~kill_ex;
    hazard     = 1'b0;
    fwd_sel    = '0;
    src        = '0;
    sel        = '0;
    ld_hit     = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      src    = id_src_addr[j*REG_AW +: REG_AW];
      sel    = '0;
      ld_hit = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (id_src_used[j] && (src != '0) && vld_eff[i] && we_q[i] && (dst_q[i] == src)) begin
          sel    = SELW'(i + 1);
          ld_hit = load_q[i] && (i < LOAD_RDY);
        end
      end
      fwd_sel[j*SELW +: SELW] = sel;
      hazard = hazard | ld_hit;
    end
  end

  assign stall = id_valid & ~flush & hazard;
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    valid_d    = '0;
    we_d       = '0;
    load_d     = '0;
    dst_d      = '0;
    valid_d[0] = issue;
    we_d[0]    = id_dst_we;
    dst_d[0]   = id_dst_addr;
    load_d[0]  = id_is_load;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = vld_eff[i-1];
      we_d[i]    = we_q[i-1];
      dst_d[i]   = dst_q[i-1];
      load_d[i]  = load_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      we_q    <= '0;
      load_q  <= '0;
      dst_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      load_q  <= load_d;
      dst_q   <= dst_d;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
